enc_link_sched: RTL and testbench



---
 rtl/enc_link_sched.sv | 138 +++++++++++++
 tb/tb_enc_link_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_link_sched.sv
// enc_link_sched: round-robin owner of the shared encoded link.
// One of eight requesters holds the link for a burst. The link carries the
// owner's 3-bit index and 2-bit payload. A burst ends on the owner's last
// beat, on the sampled beat limit, or when the owner drops its request.
module enc_link_sched (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  req_y,
    input  logic [15:0] data_y,
    input  logic [7:0]  last_y,
    input  logic [3:0]  cfg_max_beats,
    input  logic        link_ready,
    output logic [7:0]  gnt,
    output logic [2:0]  out_a,
    output logic [1:0]  out_d,
    output logic        out_valid,
    output logic        mv_scopbusy,
    output logic        RDY_mv_scopbusy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ptr;
    logic [2:0]  ptr_nxt;
    logic [4:0]  beat_cnt;
    logic [4:0]  beat_cnt_nxt;
    logic [4:0]  limit;
    logic [4:0]  limit_nxt;
    logic [7:0]  gnt_nxt;
    logic [2:0]  out_a_nxt;

    logic [2:0]  winner;
    logic [2:0]  idx;
    logic        found;
    logic        beat;
    logic        burst_end;
    logic [4:0]  cfg_limit;

    // A zero limit field stands for the largest burst of sixteen beats.
    assign cfg_limit = (cfg_max_beats == 4'd0) ? 5'd16 : {1'b0, cfg_max_beats};

    // State register: every piece of arbitration and burst state moves together.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            gnt      <= 8'h00;
            out_a    <= 3'd0;
            ptr      <= 3'd7;
            beat_cnt <= 5'd0;
            limit    <= 5'd16;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            out_a    <= out_a_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            limit    <= limit_nxt;
        end
    end

    // Next state: rotating search from ptr+1 in IDLE; beat counting and end detection in BURST.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        out_a_nxt    = out_a;
        ptr_nxt      = ptr;
        beat_cnt_nxt = beat_cnt;
        limit_nxt    = limit;
        winner       = ptr;
        idx          = ptr;
        found        = 1'b0;
        beat         = out_valid && link_ready;
        burst_end    = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req_y[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                gnt_nxt = 8'h00;
                if (found) begin
                    state_nxt    = BURST;
                    gnt_nxt      = 8'b1 << winner;
                    out_a_nxt    = winner;
                    beat_cnt_nxt = 5'd0;
                    limit_nxt    = cfg_limit;
                end
            end
            BURST: begin
                if (!req_y[out_a]) begin
                    burst_end = 1'b1;
                end else if (beat) begin
                    if (last_y[out_a] || (beat_cnt + 5'd1 == limit)) begin
                        burst_end = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 5'd1;
                    end
                end
                if (burst_end) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = 8'h00;
                    ptr_nxt      = out_a;
                    beat_cnt_nxt = 5'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
            end
        endcase
    end

    // Outputs: link view of the current owner, forced quiet while reset is held.
    always_comb begin
        out_valid       = 1'b0;
        out_d           = 2'd0;
        mv_scopbusy     = 1'b0;
        RDY_mv_scopbusy = RST_N;
        if (RST_N) begin
            out_valid   = |(req_y & gnt);
            mv_scopbusy = (state == BURST);
            if (gnt != 8'h00) begin
                out_d = data_y[{out_a, 1'b0} +: 2];
            end
        end
    end

endmodule

// File: tb/tb_enc_link_sched.sv
// tb_enc_link_sched: table vectors, directed corner sequences and random
// traffic against a behavioural model of the link scheduler.
module tb_enc_link_sched;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  req_y;
    logic [15:0] data_y;
    logic [7:0]  last_y;
    logic [3:0]  cfg_max_beats;
    logic        link_ready;
    logic [7:0]  gnt;
    logic [2:0]  out_a;
    logic [1:0]  out_d;
    logic        out_valid;
    logic        mv_scopbusy;
    logic        RDY_mv_scopbusy;

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 when the link is free), last winner, beats left.
    int m_owner;
    int m_ptr;
    int m_remaining;

    // Values seen at the most recent mid-cycle sample.
    logic [7:0] s_gnt;
    logic [2:0] s_out_a;
    logic [1:0] s_out_d;
    logic       s_valid;
    logic       s_busy;

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [15:0] data;
        logic [7:0]  last;
        logic [3:0]  cfg;
        logic        ready;
        logic [7:0]  e_gnt;
        logic [2:0]  e_a;
        logic [1:0]  e_d;
        logic        e_valid;
        logic        e_busy;
    } vec_t;

    vec_t vecs[10];

    enc_link_sched dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .req_y           (req_y),
        .data_y          (data_y),
        .last_y          (last_y),
        .cfg_max_beats   (cfg_max_beats),
        .link_ready      (link_ready),
        .gnt             (gnt),
        .out_a           (out_a),
        .out_d           (out_d),
        .out_valid       (out_valid),
        .mv_scopbusy     (mv_scopbusy),
        .RDY_mv_scopbusy (RDY_mv_scopbusy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_output();
        int e_gnt;
        int e_valid;
        int e_d;
        int e_busy;
        e_gnt   = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_valid = (RST_N && m_owner >= 0 && req_y[m_owner]) ? 1 : 0;
        e_d     = (RST_N && m_owner >= 0) ? ((int'(data_y) >> (2 * m_owner)) & 3) : 0;
        e_busy  = (RST_N && m_owner >= 0) ? 1 : 0;
        s_gnt   = gnt;
        s_out_a = out_a;
        s_out_d = out_d;
        s_valid = out_valid;
        s_busy  = mv_scopbusy;
        check_value("model_gnt", int'(gnt), e_gnt);
        check_value("model_valid", int'(out_valid), e_valid);
        check_value("model_out_d", int'(out_d), e_d);
        check_value("model_busy", int'(mv_scopbusy), e_busy);
        check_value("model_rdy", int'(RDY_mv_scopbusy), int'(RST_N));
        if (m_owner >= 0) begin
            check_value("model_out_a", int'(out_a), m_owner);
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            m_owner     = -1;
            m_ptr       = 7;
            m_remaining = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (req_y[i]) begin
                    m_owner     = i;
                    m_remaining = (cfg_max_beats == 4'd0) ? 16 : int'(cfg_max_beats);
                    break;
                end
            end
        end else if (!req_y[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (link_ready) begin
            m_remaining--;
            if (last_y[m_owner] || m_remaining == 0) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end
    endtask

    // Drives one cycle: inputs just after the edge, sample at the falling edge, model at the next rise.
    task automatic apply_stimulus(input logic rst, input logic [7:0] req, input logic [15:0] data,
                                  input logic [7:0] last, input logic [3:0] cfg, input logic ready);
        RST_N         = rst;
        req_y         = req;
        data_y        = data;
        last_y        = last;
        cfg_max_beats = cfg;
        link_ready    = ready;
        #4;
        check_output();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 8'h00, 16'h0000, 8'h00, 4'h0, 1'b1);
    endtask

    initial begin
        int beats;
        int started;
        int done;
        int exp_g;
        logic [7:0] r_req;

        RST_N         = 1'b0;
        req_y         = 8'h00;
        data_y        = 16'h0000;
        last_y        = 8'h00;
        cfg_max_beats = 4'h0;
        link_ready    = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        m_owner     = -1;
        m_ptr       = 7;
        m_remaining = 0;

        vecs[0] = '{1'b0, 8'h00, 16'h0000, 8'h00, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h01, 16'h0003, 8'h01, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h01, 16'h0003, 8'h01, 4'h0, 1'b1, 8'h01, 3'd0, 2'd3, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 16'h0003, 8'h00, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h02, 16'h0008, 8'h02, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h02, 16'h0008, 8'h02, 4'h0, 1'b1, 8'h02, 3'd1, 2'd2, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h02, 16'h0008, 8'h02, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h02, 16'h0008, 8'h00, 4'h0, 1'b0, 8'h02, 3'd1, 2'd2, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 8'h00, 16'h0008, 8'h00, 4'h0, 1'b0, 8'h02, 3'd1, 2'd2, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'h00, 16'h0008, 8'h00, 4'h0, 1'b1, 8'h00, 3'd0, 2'd0, 1'b0, 1'b0};

        for (int v = 0; v < 10; v++) begin
            apply_stimulus(vecs[v].rst, vecs[v].req, vecs[v].data, vecs[v].last,
                           vecs[v].cfg, vecs[v].ready);
            check_value($sformatf("vec%0d_gnt", v), int'(s_gnt), int'(vecs[v].e_gnt));
            check_value($sformatf("vec%0d_valid", v), int'(s_valid), int'(vecs[v].e_valid));
            check_value($sformatf("vec%0d_out_d", v), int'(s_out_d), int'(vecs[v].e_d));
            check_value($sformatf("vec%0d_busy", v), int'(s_busy), int'(vecs[v].e_busy));
            if (vecs[v].e_gnt != 8'h00) begin
                check_value($sformatf("vec%0d_out_a", v), int'(s_out_a), int'(vecs[v].e_a));
            end
        end

        // All requesters with last always set: 0..7 then 0, one bubble between grants.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            apply_stimulus(1'b1, 8'hFF, 16'($urandom), 8'hFF, 4'h0, 1'b1);
            exp_g = (c % 2 == 1) ? (1 << (((c - 1) / 2) % 8)) : 0;
            check_value($sformatf("rr_gnt_c%0d", c), int'(s_gnt), exp_g);
        end

        // Requester 5 alone with a limit of three beats.
        do_reset();
        beats = 0;
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(1'b1, 8'h20, 16'($urandom), 8'h00, 4'd3, 1'b1);
            exp_g = (c == 0 || c == 4) ? 0 : 32'h20;
            check_value($sformatf("lim3_gnt_c%0d", c), int'(s_gnt), exp_g);
            if (c >= 1 && c <= 3) begin
                check_value("lim3_out_a", int'(s_out_a), 5);
            end
            if (c >= 1 && c <= 4 && s_valid) beats++;
        end
        check_value("lim3_beats", beats, 3);

        // Zero limit field means sixteen beats.
        do_reset();
        beats   = 0;
        started = 0;
        done    = 0;
        for (int c = 0; c < 40 && done == 0; c++) begin
            apply_stimulus(1'b1, 8'h04, 16'($urandom), 8'h00, 4'd0, 1'b1);
            if (s_gnt == 8'h04 && s_valid) begin
                beats++;
                started = 1;
            end else if (started == 1 && s_gnt == 8'h00) begin
                done = 1;
            end
        end
        check_value("lim16_end_seen", done, 1);
        check_value("lim16_beats", beats, 16);

        // Requester 3: link stalls, then last on beat two; then withdrawal and pointer check.
        do_reset();
        beats = 0;
        apply_stimulus(1'b1, 8'h08, 16'h00C0, 8'h00, 4'd0, 1'b1);
        check_value("stall_idle_gnt", int'(s_gnt), 0);
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b1, 8'h08, 16'h00C0, 8'h00, 4'd0, 1'b0);
            check_value("stall_hold_gnt", int'(s_gnt), 8);
        end
        apply_stimulus(1'b1, 8'h08, 16'h0040, 8'h00, 4'd0, 1'b1);
        check_value("stall_b1_gnt", int'(s_gnt), 8);
        if (s_valid) beats++;
        apply_stimulus(1'b1, 8'h08, 16'h0080, 8'h08, 4'd0, 1'b1);
        check_value("stall_b2_gnt", int'(s_gnt), 8);
        if (s_valid) beats++;
        check_value("stall_beats", beats, 2);
        apply_stimulus(1'b1, 8'h08, 16'h0000, 8'h00, 4'd0, 1'b1);
        check_value("stall_bubble_gnt", int'(s_gnt), 0);
        apply_stimulus(1'b1, 8'h08, 16'h0000, 8'h00, 4'd0, 1'b1);
        check_value("wd_regrant_gnt", int'(s_gnt), 8);
        apply_stimulus(1'b1, 8'h00, 16'h0000, 8'h00, 4'd0, 1'b1);
        check_value("wd_drop_valid", int'(s_valid), 0);
        apply_stimulus(1'b1, 8'h11, 16'h0000, 8'h00, 4'd0, 1'b1);
        check_value("wd_idle_gnt", int'(s_gnt), 0);
        apply_stimulus(1'b1, 8'h11, 16'h0000, 8'h00, 4'd0, 1'b1);
        check_value("wd_next_gnt", int'(s_gnt), 32'h10);

        // Reset during beat two of a four-beat burst from requester 6.
        do_reset();
        apply_stimulus(1'b1, 8'h40, 16'h3000, 8'h00, 4'd4, 1'b1);
        apply_stimulus(1'b1, 8'h40, 16'h3000, 8'h00, 4'd4, 1'b1);
        check_value("rst_b1_gnt", int'(s_gnt), 32'h40);
        apply_stimulus(1'b0, 8'h40, 16'h3000, 8'h00, 4'd4, 1'b1);
        apply_stimulus(1'b1, 8'hFF, 16'hFFFF, 8'h00, 4'd4, 1'b1);
        check_value("rst_after_gnt", int'(s_gnt), 0);
        check_value("rst_after_out_a", int'(s_out_a), 0);
        check_value("rst_after_valid", int'(s_valid), 0);
        check_value("rst_after_busy", int'(s_busy), 0);
        apply_stimulus(1'b1, 8'hFF, 16'hFFFF, 8'h00, 4'd4, 1'b1);
        check_value("rst_first_gnt", int'(s_gnt), 1);

        // Random traffic against the model.
        r_req = 8'h00;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                r_req = 8'($urandom) & 8'($urandom);
            end
            apply_stimulus(($urandom_range(0, 63) != 0), r_req, 16'($urandom),
                           8'($urandom) & 8'($urandom), 4'($urandom_range(0, 15)),
                           ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
